// File: rtl/encapsulate_pkt_replay_buf.sv
// encapsulate_pkt_replay_buf: builds {dfx_data, ack, rn, sn, dst, src} packets and assigns
// sequence numbers. Up to DEPTH unacknowledged packets are kept for go-back-N replay and
// retired on cumulative acks. Ack-only packets are generated on request. The output uses a
// valid/ready handshake.
// Optional feature macro: ENCAP_PARITY_EN appends an even-parity MSB to pkt_data.
module encapsulate_pkt_replay_buf #(
  parameter int unsigned DATA_WIDTH     = 1024,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DATA_DFX_WIDTH = DATA_WIDTH + ADDR_WIDTH,
  parameter int unsigned SEQ_NUM_WIDTH  = 2,
  parameter int unsigned DFX_WIDTH      = 2,
  localparam int unsigned PKT_WIDTH     = DATA_DFX_WIDTH + 2 + SEQ_NUM_WIDTH + 2 * DFX_WIDTH,
`ifdef ENCAP_PARITY_EN
  localparam int unsigned OUT_WIDTH     = PKT_WIDTH + 1
`else
  localparam int unsigned OUT_WIDTH     = PKT_WIDTH
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_dfx_data,
  input  logic [DATA_DFX_WIDTH-1:0] dfx_data,
  input  logic                      start_encap_pkt,
  input  logic [DFX_WIDTH-1:0]      pkt_src_dfx,
  input  logic [DFX_WIDTH-1:0]      pkt_dst_dfx,
  output logic                      encap_ready,
  output logic [SEQ_NUM_WIDTH-1:0]  pkt_sn,
  output logic                      done_encap_pkt,
  input  logic                      send_ack,
  input  logic [SEQ_NUM_WIDTH-1:0]  ack_sn,
  input  logic                      ack_rx,
  input  logic [SEQ_NUM_WIDTH-1:0]  ack_rx_sn,
  input  logic                      replay_req,
  output logic [OUT_WIDTH-1:0]      pkt_data,
  output logic                      valid_pkt_send,
  input  logic                      pkt_ready,
  output logic [SEQ_NUM_WIDTH:0]    outstanding_cnt
);

  localparam int unsigned SW     = SEQ_NUM_WIDTH;
  localparam int unsigned PW     = SEQ_NUM_WIDTH + 1;  // pointer width, extra bit tells full from empty
  localparam int unsigned DEPTH  = 1 << SEQ_NUM_WIDTH;
  localparam int unsigned RN_BIT = 2 * DFX_WIDTH + SEQ_NUM_WIDTH;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENCAP    = 3'd1,
    SEND     = 3'd2,
    REPLAY   = 3'd3,
    ACK_SEND = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [PW-1:0]             head_q, head_d;
  logic [PW-1:0]             tail_q, tail_d;
  logic [PW-1:0]             rp_q, rp_d;
  logic [DATA_DFX_WIDTH-1:0] staging_q, staging_d;
  logic [DFX_WIDTH-1:0]      src_q, src_d;
  logic [DFX_WIDTH-1:0]      dst_q, dst_d;
  logic [OUT_WIDTH-1:0]      pkt_data_q, pkt_data_d;
  logic                      valid_q, valid_d;
  logic                      done_q, done_d;
  logic                      encap_ready_q, encap_ready_d;
  logic [SW-1:0]             pkt_sn_q, pkt_sn_d;
  logic [PW-1:0]             cnt_q, cnt_d;

  logic [PKT_WIDTH-1:0]      slot_q [DEPTH];
  logic                      slot_we;
  logic [PKT_WIDTH-1:0]      new_pkt;
  logic [PKT_WIDTH-1:0]      rp_pkt;
  logic [PKT_WIDTH-1:0]      ack_pkt;
  logic                      hs;
  logic [SW-1:0]             ack_k;
  logic                      retire;
  logic [PW-1:0]             retire_n;
  logic [PW-1:0]             rp_dist;

  // Append the optional parity bit to a raw packet.
  function automatic logic [OUT_WIDTH-1:0] frame(input logic [PKT_WIDTH-1:0] p);
`ifdef ENCAP_PARITY_EN
    frame = {^p, p};
`else
    frame = p;
`endif
  endfunction

  assign encap_ready     = encap_ready_q;
  assign pkt_sn          = pkt_sn_q;
  assign done_encap_pkt  = done_q;
  assign pkt_data        = pkt_data_q;
  assign valid_pkt_send  = valid_q;
  assign outstanding_cnt = cnt_q;

  // Next-state, pointer bookkeeping and output register values.
  always_comb begin
    state_d       = state_q;
    head_d        = head_q;
    tail_d        = tail_q;
    rp_d          = rp_q;
    staging_d     = staging_q;
    src_d         = src_q;
    dst_d         = dst_q;
    pkt_data_d    = pkt_data_q;
    valid_d       = valid_q;
    done_d        = 1'b0;
    pkt_sn_d      = pkt_sn_q;
    slot_we       = 1'b0;
    encap_ready_d = 1'b0;
    cnt_d         = cnt_q;
    rp_dist       = '0;

    hs       = valid_q && pkt_ready;
    new_pkt  = {staging_q, 1'b0, 1'b0, tail_q[SW-1:0], dst_q, src_q};
    ack_pkt  = {{DATA_DFX_WIDTH{1'b0}}, 1'b1, 1'b0, ack_sn, pkt_dst_dfx, pkt_src_dfx};
    rp_pkt   = slot_q[rp_q[SW-1:0]];
    rp_pkt[RN_BIT] = 1'b1;

    if (valid_dfx_data) begin
      staging_d = dfx_data;
    end

    // Cumulative ack: retire head..ack_rx_sn when it names an outstanding packet.
    ack_k    = ack_rx_sn - head_q[SW-1:0];
    retire_n = PW'(ack_k) + PW'(1);
    retire   = ack_rx && (PW'(ack_k) < cnt_q);
    if (retire) begin
      head_d = head_q + retire_n;
    end

    case (state_q)
      IDLE: begin
        if (replay_req) begin
          state_d = REPLAY;
          rp_d    = head_d;
        end else if (send_ack) begin
          pkt_data_d = frame(ack_pkt);
          valid_d    = 1'b1;
          state_d    = ACK_SEND;
        end else if (start_encap_pkt && encap_ready_q) begin
          src_d   = pkt_src_dfx;
          dst_d   = pkt_dst_dfx;
          state_d = ENCAP;
        end
      end
      ENCAP: begin
        slot_we    = 1'b1;
        pkt_data_d = frame(new_pkt);
        valid_d    = 1'b1;
        pkt_sn_d   = tail_q[SW-1:0];
        tail_d     = tail_q + PW'(1);
        state_d    = SEND;
      end
      SEND: begin
        if (hs) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      REPLAY: begin
        // rp points at the next slot to load; the beat on the output is already past it.
        if (valid_q) begin
          if (hs) begin
            valid_d = 1'b0;
          end
        end else if (rp_q == tail_q) begin
          state_d = IDLE;
        end else begin
          pkt_data_d = frame(rp_pkt);
          valid_d    = 1'b1;
          rp_d       = rp_q + PW'(1);
        end
      end
      ACK_SEND: begin
        if (hs) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    // Replay pointer never trails the head after a retire.
    if (retire) begin
      rp_dist = rp_d - head_q;
      if (rp_dist < retire_n) begin
        rp_d = head_d;
      end
    end

    cnt_d         = tail_d - head_d;
    encap_ready_d = (state_d == IDLE) && (cnt_d < PW'(DEPTH));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      head_q        <= '0;
      tail_q        <= '0;
      rp_q          <= '0;
      staging_q     <= '0;
      src_q         <= '0;
      dst_q         <= '0;
      pkt_data_q    <= '0;
      valid_q       <= 1'b0;
      done_q        <= 1'b0;
      encap_ready_q <= 1'b1;
      pkt_sn_q      <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      rp_q          <= rp_d;
      staging_q     <= staging_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      pkt_data_q    <= pkt_data_d;
      valid_q       <= valid_d;
      done_q        <= done_d;
      encap_ready_q <= encap_ready_d;
      pkt_sn_q      <= pkt_sn_d;
      cnt_q         <= cnt_d;
    end
  end

  // Replay buffer storage; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    if (slot_we) begin
      slot_q[tail_q[SW-1:0]] <= new_pkt;
    end
  end

endmodule

// File: tb/tb_encapsulate_pkt_replay_buf.sv
// Directed bench for encapsulate_pkt_replay_buf: encap latency, fill/retire, replay with
// backpressure, ack during replay, ack-only packets, sequence wrap and mid-send reset.
module tb_encapsulate_pkt_replay_buf;

  localparam int unsigned DDW = 1034;
  localparam int unsigned SW  = 2;
  localparam int unsigned DW  = 2;
  localparam int unsigned PW  = DDW + 2 + SW + 2 * DW;
`ifdef ENCAP_PARITY_EN
  localparam int unsigned OW  = PW + 1;
`else
  localparam int unsigned OW  = PW;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           valid_dfx_data;
  logic [DDW-1:0] dfx_data;
  logic           start_encap_pkt;
  logic [DW-1:0]  pkt_src_dfx, pkt_dst_dfx;
  logic           encap_ready;
  logic [SW-1:0]  pkt_sn;
  logic           done_encap_pkt;
  logic           send_ack;
  logic [SW-1:0]  ack_sn;
  logic           ack_rx;
  logic [SW-1:0]  ack_rx_sn;
  logic           replay_req;
  logic [OW-1:0]  pkt_data;
  logic           valid_pkt_send;
  logic           pkt_ready;
  logic [SW:0]    outstanding_cnt;

  int n_cmp = 0;
  int n_err = 0;

  encapsulate_pkt_replay_buf dut (
    .clk             (clk),
    .rst             (rst),
    .valid_dfx_data  (valid_dfx_data),
    .dfx_data        (dfx_data),
    .start_encap_pkt (start_encap_pkt),
    .pkt_src_dfx     (pkt_src_dfx),
    .pkt_dst_dfx     (pkt_dst_dfx),
    .encap_ready     (encap_ready),
    .pkt_sn          (pkt_sn),
    .done_encap_pkt  (done_encap_pkt),
    .send_ack        (send_ack),
    .ack_sn          (ack_sn),
    .ack_rx          (ack_rx),
    .ack_rx_sn       (ack_rx_sn),
    .replay_req      (replay_req),
    .pkt_data        (pkt_data),
    .valid_pkt_send  (valid_pkt_send),
    .pkt_ready       (pkt_ready),
    .outstanding_cnt (outstanding_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DDW-1:0] data;
    logic [DW-1:0]  src;
    logic [DW-1:0]  dst;
    logic [SW-1:0]  exp_sn;
  } vec_t;

  vec_t tv [10];

  function automatic logic [OW-1:0] mk(input logic [DDW-1:0] d, input logic a, input logic r,
                                       input logic [SW-1:0] sn, input logic [DW-1:0] dst,
                                       input logic [DW-1:0] src);
    logic [PW-1:0] p;
    p = {d, a, r, sn, dst, src};
`ifdef ENCAP_PARITY_EN
    mk = {^p, p};
`else
    mk = p;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_pkt(input string nm, input logic [OW-1:0] exp);
    n_cmp++;
    if (pkt_data !== exp) begin
      n_err++;
      $display("FAIL %s: got hi=%h lo=%h expected hi=%h lo=%h", nm,
               pkt_data[OW-1 -: 32], pkt_data[63:0], exp[OW-1 -: 32], exp[63:0]);
    end
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!valid_pkt_send && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    if (!valid_pkt_send) begin
      n_err++;
      $display("FAIL %s: valid_pkt_send got 0 expected 1 within 20 cycles", nm);
    end
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!encap_ready && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    if (!encap_ready) begin
      n_err++;
      $display("FAIL %s: encap_ready got 0 expected 1 within 20 cycles", nm);
    end
  endtask

  // Stage tv[i], start it, and check the encap latency, packet and done pulse (pkt_ready=1).
  task automatic send_data(input int i);
    dfx_data       = tv[i].data;
    valid_dfx_data = 1'b1;
    tick();
    valid_dfx_data  = 1'b0;
    dfx_data        = '0;
    start_encap_pkt = 1'b1;
    pkt_src_dfx     = tv[i].src;
    pkt_dst_dfx     = tv[i].dst;
    tick();
    start_encap_pkt = 1'b0;
    pkt_src_dfx     = '0;
    pkt_dst_dfx     = '0;
    chk($sformatf("v%0d_valid_t1", i), 32'(valid_pkt_send), 32'd0);
    tick();
    chk($sformatf("v%0d_valid_t2", i), 32'(valid_pkt_send), 32'd1);
    chk_pkt($sformatf("v%0d_pkt", i), mk(tv[i].data, 1'b0, 1'b0, tv[i].exp_sn, tv[i].dst, tv[i].src));
    chk($sformatf("v%0d_pkt_sn", i), 32'(pkt_sn), 32'(tv[i].exp_sn));
    tick();
    chk($sformatf("v%0d_done", i), 32'(done_encap_pkt), 32'd1);
    chk($sformatf("v%0d_valid_off", i), 32'(valid_pkt_send), 32'd0);
  endtask

  task automatic do_ack(input logic [SW-1:0] sn);
    ack_rx    = 1'b1;
    ack_rx_sn = sn;
    tick();
    ack_rx    = 1'b0;
    ack_rx_sn = '0;
  endtask

  initial begin
    for (int i = 0; i < 10; i++) begin
      tv[i].data            = '0;
      tv[i].data[31:0]      = 32'hC0DE_0000 + 32'(i);
      tv[i].data[DDW-1 -: 32] = 32'hA5A5_0000 + 32'(i * 17);
      tv[i].src             = DW'(i);
      tv[i].dst             = DW'(3 - (i % 4));
      tv[i].exp_sn          = (i < 4) ? SW'(i) : SW'(i - 4);
    end

    rst = 1'b1; valid_dfx_data = 1'b0; dfx_data = '0; start_encap_pkt = 1'b0;
    pkt_src_dfx = '0; pkt_dst_dfx = '0; send_ack = 1'b0; ack_sn = '0;
    ack_rx = 1'b0; ack_rx_sn = '0; replay_req = 1'b0; pkt_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_encap_ready", 32'(encap_ready), 32'd1);
    chk("rst_valid", 32'(valid_pkt_send), 32'd0);
    chk("rst_cnt", 32'(outstanding_cnt), 32'd0);
    chk("rst_done", 32'(done_encap_pkt), 32'd0);
    chk("rst_pkt_sn", 32'(pkt_sn), 32'd0);
    chk_pkt("rst_pkt_data", '0);

    // Single packet, then fill to DEPTH.
    send_data(0);
    chk("t1_cnt", 32'(outstanding_cnt), 32'd1);
    for (int i = 1; i < 4; i++) send_data(i);
    tick();
    chk("t2_cnt_full", 32'(outstanding_cnt), 32'd4);
    chk("t2_not_ready", 32'(encap_ready), 32'd0);
    start_encap_pkt = 1'b1;
    tick();
    start_encap_pkt = 1'b0;
    tick();
    tick();
    chk("t2_fifth_valid", 32'(valid_pkt_send), 32'd0);
    chk("t2_fifth_cnt", 32'(outstanding_cnt), 32'd4);
    do_ack(2'd1);
    chk("t2_ack_cnt", 32'(outstanding_cnt), 32'd2);
    chk("t2_ack_ready", 32'(encap_ready), 32'd1);

    // Replay sn2, sn3 with backpressure.
    pkt_ready  = 1'b0;
    replay_req = 1'b1;
    tick();
    replay_req = 1'b0;
    wait_valid("t3_wait_sn2");
    chk_pkt("t3_sn2", mk(tv[2].data, 1'b0, 1'b1, 2'd2, tv[2].dst, tv[2].src));
    tick();
    chk_pkt("t3_sn2_stall1", mk(tv[2].data, 1'b0, 1'b1, 2'd2, tv[2].dst, tv[2].src));
    tick();
    chk("t3_sn2_stall_valid", 32'(valid_pkt_send), 32'd1);
    pkt_ready = 1'b1;
    tick();
    pkt_ready = 1'b0;
    wait_valid("t3_wait_sn3");
    chk_pkt("t3_sn3", mk(tv[3].data, 1'b0, 1'b1, 2'd3, tv[3].dst, tv[3].src));
    tick();
    chk_pkt("t3_sn3_stall", mk(tv[3].data, 1'b0, 1'b1, 2'd3, tv[3].dst, tv[3].src));
    pkt_ready = 1'b1;
    tick();
    pkt_ready = 1'b0;
    wait_ready("t3_back_idle");
    chk("t3_cnt", 32'(outstanding_cnt), 32'd2);
    chk("t3_no_extra_beat", 32'(valid_pkt_send), 32'd0);

    // Ack sn2 while replay is stalled on sn2.
    replay_req = 1'b1;
    tick();
    replay_req = 1'b0;
    wait_valid("t4_wait_sn2");
    do_ack(2'd2);
    chk("t4_cnt", 32'(outstanding_cnt), 32'd1);
    chk_pkt("t4_sn2_held", mk(tv[2].data, 1'b0, 1'b1, 2'd2, tv[2].dst, tv[2].src));
    pkt_ready = 1'b1;
    tick();
    pkt_ready = 1'b0;
    wait_valid("t4_wait_sn3");
    chk_pkt("t4_sn3", mk(tv[3].data, 1'b0, 1'b1, 2'd3, tv[3].dst, tv[3].src));
    pkt_ready = 1'b1;
    tick();
    wait_ready("t4_back_idle");
    chk("t4_no_extra_beat", 32'(valid_pkt_send), 32'd0);
    do_ack(2'd0);
    chk("t4_stale_ack_cnt", 32'(outstanding_cnt), 32'd1);

    // Ack-only packet beats a concurrent start.
    send_ack        = 1'b1;
    ack_sn          = 2'd3;
    start_encap_pkt = 1'b1;
    pkt_src_dfx     = 2'd1;
    pkt_dst_dfx     = 2'd2;
    tick();
    send_ack = 1'b0; ack_sn = '0; start_encap_pkt = 1'b0; pkt_src_dfx = '0; pkt_dst_dfx = '0;
    chk("t5_valid", 32'(valid_pkt_send), 32'd1);
    chk_pkt("t5_ack_pkt", mk('0, 1'b1, 1'b0, 2'd3, 2'd2, 2'd1));
    tick();
    chk("t5_valid_off", 32'(valid_pkt_send), 32'd0);
    chk("t5_no_done", 32'(done_encap_pkt), 32'd0);
    tick();
    tick();
    chk("t5_start_dropped", 32'(valid_pkt_send), 32'd0);
    chk("t5_cnt", 32'(outstanding_cnt), 32'd1);
    do_ack(2'd3);
    chk("t5_cnt_empty", 32'(outstanding_cnt), 32'd0);

    // Replay with nothing outstanding.
    replay_req = 1'b1;
    tick();
    replay_req = 1'b0;
    chk("er_busy", 32'(encap_ready), 32'd0);
    tick();
    chk("er_idle", 32'(encap_ready), 32'd1);
    chk("er_no_valid", 32'(valid_pkt_send), 32'd0);

    // Sequence-number wrap, each packet acked.
    for (int i = 4; i < 10; i++) begin
      send_data(i);
      do_ack(tv[i].exp_sn);
      chk($sformatf("wrap%0d_cnt", i), 32'(outstanding_cnt), 32'd0);
    end

    // Reset while a packet is held in SEND.
    pkt_ready       = 1'b0;
    start_encap_pkt = 1'b1;
    tick();
    start_encap_pkt = 1'b0;
    wait_valid("rst_mid_wait");
    chk("rst_mid_cnt_before", 32'(outstanding_cnt), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", 32'(valid_pkt_send), 32'd0);
    chk("rst_mid_cnt", 32'(outstanding_cnt), 32'd0);
    chk("rst_mid_ready", 32'(encap_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
